// File: rtl/lsu_unit.sv
// RV32 load/store unit: passes the effective address to data memory, lane-aligns
// store data, builds byte enables, extends load data and records misaligned faults.
module lsu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] write_data,
    input  logic             mem_write,
    input  logic             mem_read,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             fault_clear,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    output logic             mem_re,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] load_data,
    output logic             misaligned,
    output logic             fault_valid,
    output logic [WIDTH-1:0] fault_addr,
    output logic             fault_store
);

    logic [1:0]       off;
    logic [4:0]       shamt;
    logic             req;
    logic             is_byte;
    logic             is_half;
    logic             is_word;
    logic             is_reserved;
    logic [3:0]       be_raw;
    logic [WIDTH-1:0] lane;

    logic             fault_valid_reg;
    logic             fault_valid_next;
    logic [WIDTH-1:0] fault_addr_reg;
    logic [WIDTH-1:0] fault_addr_next;
    logic             fault_store_reg;
    logic             fault_store_next;

    assign off   = alu_result[1:0];
    assign shamt = {off, 3'b000};
    assign req   = mem_write | mem_read;

    assign mem_addr  = alu_result;
    assign mem_we    = mem_write;
    assign mem_re    = mem_read;
    assign mem_wdata = write_data << shamt;

    always_comb begin
        is_byte     = 1'b0;
        is_half     = 1'b0;
        is_word     = 1'b0;
        is_reserved = 1'b0;
        case (funct3)
            3'b000, 3'b100: is_byte     = 1'b1;
            3'b001, 3'b101: is_half     = 1'b1;
            3'b010:         is_word     = 1'b1;
            default:        is_reserved = 1'b1;
        endcase
    end

    assign misaligned = req & (is_reserved
                             | (is_half & off[0])
                             | (is_word & (off != 2'b00)));

    always_comb begin
        be_raw = 4'b0000;
        if (is_byte) begin
            be_raw = 4'b0001 << off;
        end else if (is_half) begin
            be_raw = 4'b0011 << off;
        end else if (is_word) begin
            be_raw = 4'b1111;
        end
    end

    // Misaligned accesses still drive we/re; the lanes are what get suppressed.
    assign mem_be = (req && !misaligned) ? be_raw : 4'b0000;

    assign lane = mem_rdata >> shamt;

    always_comb begin
        load_data = '0;
        if (mem_read && !misaligned) begin
            case (funct3)
                3'b000:  load_data = {{(WIDTH-8){lane[7]}}, lane[7:0]};
                3'b100:  load_data = {{(WIDTH-8){1'b0}}, lane[7:0]};
                3'b001:  load_data = {{(WIDTH-16){lane[15]}}, lane[15:0]};
                3'b101:  load_data = {{(WIDTH-16){1'b0}}, lane[15:0]};
                3'b010:  load_data = mem_rdata;
                default: load_data = '0;
            endcase
        end
    end

    // First fault sticks until cleared; a clear in the same cycle beats a new capture.
    always_comb begin
        fault_valid_next = fault_valid_reg;
        fault_addr_next  = fault_addr_reg;
        fault_store_next = fault_store_reg;
        if (fault_clear) begin
            fault_valid_next = 1'b0;
        end else if (misaligned && !fault_valid_reg) begin
            fault_valid_next = 1'b1;
            fault_addr_next  = alu_result;
            fault_store_next = mem_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_valid_reg <= 1'b0;
            fault_addr_reg  <= '0;
            fault_store_reg <= 1'b0;
        end else begin
            fault_valid_reg <= fault_valid_next;
            fault_addr_reg  <= fault_addr_next;
            fault_store_reg <= fault_store_next;
        end
    end

    assign fault_valid = fault_valid_reg;
    assign fault_addr  = fault_addr_reg;
    assign fault_store = fault_store_reg;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: combinational datapath vectors, fault record
// capture/hold/clear, and asynchronous reset of the record.
module tb_lsu_unit;

    logic        clk;
    logic        rst;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic [2:0]  funct3;
    logic [31:0] mem_rdata;
    logic        fault_clear;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [3:0]  mem_be;
    logic [31:0] load_data;
    logic        misaligned;
    logic        fault_valid;
    logic [31:0] fault_addr;
    logic        fault_store;

    int checks   = 0;
    int failures = 0;

    lsu_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_result  (alu_result),
        .write_data  (write_data),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .funct3      (funct3),
        .mem_rdata   (mem_rdata),
        .fault_clear (fault_clear),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_be      (mem_be),
        .load_data   (load_data),
        .misaligned  (misaligned),
        .fault_valid (fault_valid),
        .fault_addr  (fault_addr),
        .fault_store (fault_store)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic wr, input logic rd, input logic [2:0] f3);
        alu_result = addr;
        mem_write  = wr;
        mem_read   = rd;
        funct3     = f3;
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        alu_result  = 32'h0;
        write_data  = 32'h0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        funct3      = 3'b000;
        mem_rdata   = 32'h0;
        fault_clear = 1'b1;
        #2;
        check("reset_fault_valid", {31'b0, fault_valid}, 32'h0);
        check("reset_fault_addr", fault_addr, 32'h0);
        check("reset_fault_store", {31'b0, fault_store}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        $display("step reset released");

        // Combinational vectors with fault_clear held high so nothing is captured
        write_data = 32'hDEADBEEF;
        drive(32'h10, 1'b1, 1'b0, 3'b010);
        check("sw_addr", mem_addr, 32'h10);
        check("sw_wdata", mem_wdata, 32'hDEADBEEF);
        check("sw_we", {31'b0, mem_we}, 32'h1);
        check("sw_re", {31'b0, mem_re}, 32'h0);
        check("sw_be", {28'b0, mem_be}, 32'hF);
        check("sw_mis", {31'b0, misaligned}, 32'h0);
        $display("step SW @0x10");

        drive(32'h10, 1'b0, 1'b0, 3'b010);
        check("idle_we", {31'b0, mem_we}, 32'h0);
        check("idle_be", {28'b0, mem_be}, 32'h0);
        check("idle_addr", mem_addr, 32'h10);
        $display("step no request @0x10");

        drive(32'h10, 1'b0, 1'b0, 3'b011);
        check("idle_reserved_mis", {31'b0, misaligned}, 32'h0);
        $display("step reserved funct3 without request");

        write_data = 32'h000000AB;
        drive(32'h13, 1'b1, 1'b0, 3'b000);
        check("sb13_wdata", mem_wdata, 32'hAB000000);
        check("sb13_be", {28'b0, mem_be}, 32'h8);
        $display("step SB @0x13");

        drive(32'h11, 1'b1, 1'b0, 3'b000);
        check("sb11_wdata", mem_wdata, 32'h0000AB00);
        check("sb11_be", {28'b0, mem_be}, 32'h2);
        $display("step SB @0x11");

        drive(32'h12, 1'b1, 1'b0, 3'b001);
        check("sh12_be", {28'b0, mem_be}, 32'hC);
        check("sh12_wdata", mem_wdata, 32'h00AB0000);
        check("sh12_mis", {31'b0, misaligned}, 32'h0);
        $display("step SH @0x12");

        mem_rdata = 32'h80F17F80;
        drive(32'h0, 1'b0, 1'b1, 3'b000);
        check("lb0", load_data, 32'hFFFFFF80);
        check("lb0_be", {28'b0, mem_be}, 32'h1);
        check("lb0_re", {31'b0, mem_re}, 32'h1);
        drive(32'h0, 1'b0, 1'b1, 3'b100);
        check("lbu0", load_data, 32'h00000080);
        drive(32'h1, 1'b0, 1'b1, 3'b000);
        check("lb1", load_data, 32'h0000007F);
        drive(32'h3, 1'b0, 1'b1, 3'b000);
        check("lb3", load_data, 32'hFFFFFF80);
        drive(32'h2, 1'b0, 1'b1, 3'b001);
        check("lh2", load_data, 32'hFFFF80F1);
        drive(32'h2, 1'b0, 1'b1, 3'b101);
        check("lhu2", load_data, 32'h000080F1);
        drive(32'h0, 1'b0, 1'b1, 3'b001);
        check("lh0", load_data, 32'h00007F80);
        drive(32'h0, 1'b0, 1'b1, 3'b010);
        check("lw0", load_data, 32'h80F17F80);
        $display("step loads from 0x80F17F80");

        drive(32'h1, 1'b0, 1'b1, 3'b001);
        check("lh1_mis", {31'b0, misaligned}, 32'h1);
        check("lh1_be", {28'b0, mem_be}, 32'h0);
        check("lh1_data", load_data, 32'h0);
        drive(32'h0, 1'b0, 1'b1, 3'b110);
        check("rsv_mis", {31'b0, misaligned}, 32'h1);
        check("rsv_data", load_data, 32'h0);
        check("rsv_re", {31'b0, mem_re}, 32'h1);
        drive(32'h0, 1'b0, 1'b0, 3'b010);
        check("noread_data", load_data, 32'h0);
        $display("step misaligned/reserved/no-read loads");

        // Fault record
        @(negedge clk);
        fault_clear = 1'b0;
        drive(32'h21, 1'b0, 1'b1, 3'b010);
        check("lw21_mis", {31'b0, misaligned}, 32'h1);
        check("lw21_be", {28'b0, mem_be}, 32'h0);
        check("lw21_data", load_data, 32'h0);
        check("lw21_pre_valid", {31'b0, fault_valid}, 32'h0);
        @(posedge clk); #1;
        check("cap_valid", {31'b0, fault_valid}, 32'h1);
        check("cap_addr", fault_addr, 32'h21);
        check("cap_store", {31'b0, fault_store}, 32'h0);
        $display("step fault captured @0x21");

        drive(32'h33, 1'b1, 1'b0, 3'b001);
        @(posedge clk); #1;
        check("hold_valid", {31'b0, fault_valid}, 32'h1);
        check("hold_addr", fault_addr, 32'h21);
        check("hold_store", {31'b0, fault_store}, 32'h0);
        $display("step second fault @0x33 ignored");

        fault_clear = 1'b1;
        @(posedge clk); #1;
        check("clear_wins_valid", {31'b0, fault_valid}, 32'h0);
        $display("step clear with concurrent fault");

        fault_clear = 1'b0;
        drive(32'h40, 1'b0, 1'b1, 3'b010);
        @(posedge clk); #1;
        check("aligned_no_cap", {31'b0, fault_valid}, 32'h0);
        $display("step aligned access no capture");

        drive(32'h2, 1'b1, 1'b1, 3'b010);
        check("rw_be", {28'b0, mem_be}, 32'h0);
        @(posedge clk); #1;
        check("rw_valid", {31'b0, fault_valid}, 32'h1);
        check("rw_addr", fault_addr, 32'h2);
        check("rw_store", {31'b0, fault_store}, 32'h1);
        $display("step read+write fault recorded as store");

        // Asynchronous reset between clock edges
        @(negedge clk);
        drive(32'h55, 1'b0, 1'b0, 3'b010);
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, fault_valid}, 32'h0);
        check("arst_addr", fault_addr, 32'h0);
        check("arst_store", {31'b0, fault_store}, 32'h0);
        check("arst_comb_addr", mem_addr, 32'h55);
        $display("step async reset clears record");
        @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
